mandelbrot_iter_engine: RTL and testbench
=========================================

// Module: mandelbrot_iter_engine
// PURPOSE
//  Per-pixel escape-time engine; upstream producer of the colour mapper's iteration_count/in_set.
//  Accepts one complex point c over a valid/ready handshake and iterates z <- z^2 + c from z0 = 0.
//  Returns the escape iteration count, or in_set = 1 if max_iter is reached without escape.
//  One iteration per clock; one pixel in flight at a time.
// PARAMETERS
//  WIDTH    12  signed fixed-point width of c_re, c_im, z (Q3.9 at defaults, range [-4,4))
//  FRAC     9   fractional bits
//  ITER_W   6   width of max_iter and iteration_count
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       asynchronous active-low reset
//  in_valid         in   1       c_re/c_im/max_iter valid
//  in_ready         out  1       engine idle, can accept a point
//  c_re             in   WIDTH   real part of c, signed fixed
//  c_im             in   WIDTH   imag part of c, signed fixed
//  max_iter         in   ITER_W  iteration limit, sampled on accept
//  out_valid        out  1       result valid, held until out_ready
//  out_ready        in   1       downstream accepts result
//  iteration_count  out  ITER_W  escape iteration k, or max_iter if in set
//  in_set           out  1       1 = limit reached without escape
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, iteration_count=0, in_set=0; z, iter, c regs cleared.
//  Reset mid-operation aborts the point immediately; no result is produced.
//  FSM IDLE -> ITER on (in_valid && in_ready): latch c, max_iter; z_re = z_im = 0; iter = 0.
//  in_ready = (state == IDLE) only. No accept in ITER or DONE.
//  ITER, each cycle, in priority order:
//   1. iter == max_iter        -> iteration_count = max_iter, in_set = 1, go DONE
//   2. zr2 + zi2 >= 4.0        -> iteration_count = iter, in_set = 0, go DONE (escape)
//   3. otherwise: z_re = sat(zr2 - zi2 + c_re), z_im = sat(2*zr*zi + c_im), iter++
//  Arithmetic:
//   - products are full 2*WIDTH signed, then arithmetic-shifted right by FRAC (truncation toward -inf)
//   - 2*zr*zi uses a shift of FRAC-1
//   - magnitude sum is computed at 2*WIDTH+1 bits and compared against 4 << FRAC; no overflow is allowed
//   - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//  DONE: out_valid = 1; iteration_count and in_set are stable while out_valid && !out_ready.
//   On out_ready -> IDLE next cycle, out_valid = 0; outputs keep their last value.
//  Latency: accept at cycle T; escape at k -> out_valid at T+k+2; in-set -> T+max_iter+2.
//  max_iter = 0: rule 1 fires on the first ITER cycle; in_set = 1, count = 0, out_valid at T+2.
//  iter never wraps: the limit check precedes increment, and iter <= max_iter <= 2^ITER_W-1.
// CONFIGURATION
//  MANDEL_BULB_CHECK_EN defined: on the first ITER cycle, before rule 1, test the period-2 bulb:
//   (c_re + 1)^2 + c_im^2 < 1/16. If true: in_set = 1, count = max_iter, go DONE (out_valid at T+2).
//   Uses the same fixed-point truncation rules.
//  Undefined: no bulb test; the first ITER cycle follows rules 1-3 only. Results are identical
//   except latency (and truncation-edge points on the bulb boundary).
// STRUCTURE
//  mandelbrot_pkg:
//   - fixed-point typedef fxp_t (logic signed [WIDTH-1:0])
//   - FRAC, ESCAPE_THRESH (4 << FRAC) and BULB_THRESH constants
//   - state enum {IDLE, ITER, DONE}
//  Sub-module mandelbrot_iter_step (combinational): z, c -> next z, escape flag.
//   Holds the three multipliers and saturation. FSM, counters and handshake stay in this module.
// TESTING
//  - c = (0,0), max_iter = 20 -> in_set = 1, count = 20, out_valid 22 cycles after accept.
//  - c = (2.0,0) = (1024,0) -> escape at k = 1: in_set = 0, count = 1, out_valid at T+3.
//  - c = (0.5,0) = (256,0), max_iter = 63 -> count = 5, in_set = 0 (z4 = 834/512, z5 = 1614/512).
//  - c = (-1,0), max_iter = 63 -> in_set = 1, count = 63; with MANDEL_BULB_CHECK_EN, out_valid at T+2.
//  - Hold out_ready = 0 for 10 cycles in DONE -> out_valid, outputs and in_ready = 0 stable; in_valid ignored.
//  - max_iter = 0 -> in_set = 1, count = 0; assert rst_n low mid-ITER -> all outputs at reset values,
//    in_ready = 1.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine.
// Q3.9 fixed point at defaults: fxp_t, FRAC, escape/bulb thresholds, FSM states.
package mandelbrot_pkg;

    localparam int FXP_W = 12;
    localparam int FRAC  = 9;

    typedef logic signed [FXP_W-1:0] fxp_t;

    // |z|^2 escape limit (4.0) and period-2 bulb radius^2 (1/16)
    localparam int ESCAPE_THRESH = 4 << FRAC;
    localparam int BULB_THRESH   = 1 << (FRAC - 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandelbrot_iter_step.sv
// One combinational z <- z^2 + c step with saturation, plus the escape test on the current z.
// Ports: z_re/z_im (current z), c_re/c_im, z_re_nx/z_im_nx (next z), escape (|z|^2 >= 4).
module mandelbrot_iter_step #(
    parameter int WIDTH = 12,
    parameter int FRAC  = 9
) (
    input  logic signed [WIDTH-1:0] z_re,
    input  logic signed [WIDTH-1:0] z_im,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    output logic signed [WIDTH-1:0] z_re_nx,
    output logic signed [WIDTH-1:0] z_im_nx,
    output logic                    escape
);

    localparam int PW = 2 * WIDTH;

    localparam logic signed [PW:0]   ESC_T = (PW+1)'(4 << FRAC);
    localparam logic signed [PW+1:0] MAX_V = (PW+2)'((1 << (WIDTH-1)) - 1);
    localparam logic signed [PW+1:0] MIN_V = (PW+2)'(-(1 << (WIDTH-1)));

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW+1:0] v);
        if (v > MAX_V) return {1'b0, {(WIDTH-1){1'b1}}};
        if (v < MIN_V) return {1'b1, {(WIDTH-1){1'b0}}};
        return v[WIDTH-1:0];
    endfunction

    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] sq_rr;
    logic signed [PW-1:0] sq_ii;
    logic signed [PW-1:0] ri2;
    logic signed [PW:0]   mag;
    logic signed [PW+1:0] re_sum;
    logic signed [PW+1:0] im_sum;

    assign p_rr = z_re * z_re;
    assign p_ii = z_im * z_im;
    assign p_ri = z_re * z_im;

    // Arithmetic shifts truncate toward -inf; the cross term folds in the x2
    assign sq_rr = p_rr >>> FRAC;
    assign sq_ii = p_ii >>> FRAC;
    assign ri2   = p_ri >>> (FRAC - 1);

    assign mag    = sq_rr + sq_ii;
    assign escape = (mag >= ESC_T);

    assign re_sum = sq_rr - sq_ii + c_re;
    assign im_sum = ri2 + c_im;

    assign z_re_nx = sat(re_sum);
    assign z_im_nx = sat(im_sum);

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Escape-time engine: accepts c over valid/ready, iterates one step per clock, returns count/in_set.
// Ports: clk, rst_n, in_valid/in_ready, c_re, c_im, max_iter, out_valid/out_ready, iteration_count, in_set.
// Option: define MANDEL_BULB_CHECK_EN to short-circuit points inside the period-2 bulb.
module mandelbrot_iter_engine #(
    parameter int WIDTH  = 12,
    parameter int FRAC   = 9,
    parameter int ITER_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    input  logic [ITER_W-1:0]       max_iter,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_W-1:0]       iteration_count,
    output logic                    in_set
);

    import mandelbrot_pkg::*;

    state_t state, state_d;

    logic signed [WIDTH-1:0] z_re, z_im, c_re_q, c_im_q;
    logic signed [WIDTH-1:0] z_re_d, z_im_d, c_re_d, c_im_d;
    logic signed [WIDTH-1:0] z_re_nx, z_im_nx;
    logic [ITER_W-1:0]       iter, iter_d, max_q, max_d, cnt_d;
    logic                    in_set_d;
    logic                    escape;
    logic                    bulb_hit;

    mandelbrot_iter_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_step (
        .z_re    (z_re),
        .z_im    (z_im),
        .c_re    (c_re_q),
        .c_im    (c_im_q),
        .z_re_nx (z_re_nx),
        .z_im_nx (z_im_nx),
        .escape  (escape)
    );

`ifdef MANDEL_BULB_CHECK_EN
    localparam int BW = 2 * WIDTH + 3;
    localparam logic signed [BW-1:0] BULB_T = BW'(1 << (FRAC - 4));

    logic signed [WIDTH:0]     cr1;
    logic signed [2*WIDTH+1:0] b_rr;
    logic signed [2*WIDTH-1:0] b_ii;
    logic signed [BW-1:0]      b_sum;

    // (c_re + 1)^2 + c_im^2, widened so the +1 offset cannot overflow
    assign cr1   = $signed({c_re_q[WIDTH-1], c_re_q}) + $signed((WIDTH+1)'(1 << FRAC));
    assign b_rr  = cr1 * cr1;
    assign b_ii  = c_im_q * c_im_q;
    assign b_sum = (b_rr >>> FRAC) + (b_ii >>> FRAC);

    // iter is zero only on the first ITER cycle
    assign bulb_hit = (b_sum < BULB_T) && (iter == '0);
`else
    assign bulb_hit = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_d  = state;
        z_re_d   = z_re;
        z_im_d   = z_im;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        iter_d   = iter;
        max_d    = max_q;
        cnt_d    = iteration_count;
        in_set_d = in_set;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = ITER;
                    c_re_d  = c_re;
                    c_im_d  = c_im;
                    max_d   = max_iter;
                    z_re_d  = '0;
                    z_im_d  = '0;
                    iter_d  = '0;
                end
            end
            ITER: begin
                if (bulb_hit || (iter == max_q)) begin
                    cnt_d    = max_q;
                    in_set_d = 1'b1;
                    state_d  = DONE;
                end else if (escape) begin
                    cnt_d    = iter;
                    in_set_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    z_re_d = z_re_nx;
                    z_im_d = z_im_nx;
                    iter_d = iter + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            z_re            <= '0;
            z_im            <= '0;
            c_re_q          <= '0;
            c_im_q          <= '0;
            iter            <= '0;
            max_q           <= '0;
            iteration_count <= '0;
            in_set          <= 1'b0;
        end else begin
            state           <= state_d;
            z_re            <= z_re_d;
            z_im            <= z_im_d;
            c_re_q          <= c_re_d;
            c_im_q          <= c_im_d;
            iter            <= iter_d;
            max_q           <= max_d;
            iteration_count <= cnt_d;
            in_set          <= in_set_d;
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Scoreboard bench for mandelbrot_iter_engine: reference model, handshake hold, max_iter=0, mid-run reset.
// Honours MANDEL_BULB_CHECK_EN in its model when the design is built with it.
module tb_mandelbrot_iter_engine;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [11:0] c_re;
    logic signed [11:0] c_im;
    logic [5:0]        max_iter;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        iteration_count;
    logic              in_set;

    typedef struct {
        int cnt;
        int ins;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .c_re            (c_re),
        .c_im            (c_im),
        .max_iter        (max_iter),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .iteration_count (iteration_count),
        .in_set          (in_set)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat12(input longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Escape-time reference on plain integers (Q3.9)
    function automatic exp_t model(input int cr, input int ci, input int mi);
        exp_t   e;
        longint zr = 0;
        longint zi = 0;
        longint a, b, nr, ni;
        int     it = 0;
`ifdef MANDEL_BULB_CHECK_EN
        longint d = longint'(cr) + 512;
        if (((d * d) >>> 9) + ((longint'(ci) * ci) >>> 9) < 32) begin
            e.cnt = mi; e.ins = 1; e.lat = 2;
            return e;
        end
`endif
        while (1) begin
            if (it == mi) begin
                e.cnt = mi; e.ins = 1; e.lat = mi + 2;
                return e;
            end
            a = (zr * zr) >>> 9;
            b = (zi * zi) >>> 9;
            if (a + b >= 2048) begin
                e.cnt = it; e.ins = 0; e.lat = it + 2;
                return e;
            end
            nr = sat12(a - b + cr);
            ni = sat12(((zr * zi) >>> 8) + ci);
            zr = nr;
            zi = ni;
            it++;
        end
    endfunction

    task automatic run_point(input int cr, input int ci, input int mi, input bit hold);
        exp_t e;
        int   w;
        int   lat;
        int   hc;
        int   hs;
        sb.push_back(model(cr, ci, mi));
        @(negedge clk);
        c_re     = 12'(cr);
        c_im     = 12'(ci);
        max_iter = 6'(mi);
        in_valid = 1'b1;
        if (hold) out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        if (hold) begin
            c_re = 12'sd100;
            c_im = -12'sd50;
            max_iter = 6'd3;
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("count", int'(iteration_count), e.cnt);
        chk("in_set", int'(in_set), e.ins);
        chk("latency", lat, e.lat);
        if (hold) begin
            hc = int'(iteration_count);
            hs = int'(in_set);
            repeat (10) begin
                @(negedge clk);
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_count", int'(iteration_count), hc);
                chk("hold_in_set", int'(in_set), hs);
                chk("hold_ready", int'(in_ready), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
        chk("keep_count", int'(iteration_count), e.cnt);
    endtask

    initial begin
        logic [11:0] r;
        int          cr, ci, seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c_re      = '0;
        c_im      = '0;
        max_iter  = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(iteration_count), 0);
        chk("rst_in_set", int'(in_set), 0);
        rst_n = 1'b1;

        run_point(0, 0, 20, 1'b0);
        run_point(1024, 0, 63, 1'b0);
        run_point(256, 0, 63, 1'b0);
        run_point(300, -200, 0, 1'b0);
        run_point(-400, 300, 15, 1'b1);
        run_point(-800, 2047, 40, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r  = 12'($urandom);
            cr = {{20{r[11]}}, r};
            r  = 12'($urandom);
            ci = {{20{r[11]}}, r};
            run_point(cr, ci, int'($urandom_range(0, 40)), 1'b0);
        end

        run_point(-512, 0, 63, 1'b0);

        // Abort a point mid-iteration
        @(negedge clk);
        c_re     = '0;
        c_im     = '0;
        max_iter = 6'd63;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(iteration_count), 0);
        chk("mid_rst_in_set", int'(in_set), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_rst", seen, 0);
        chk("idle_after_rst", int'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
